// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexes four of the six BCD clock digits onto a
// 4-digit common-anode seven-segment display (Basys3). Supports HH.MM / MM.SS
// selection, leading-hour-zero blanking, a blinking separator dot and a
// short all-anodes-off guard at the start of every digit slot to stop ghosting.
// All pin-facing outputs come straight from flops.
module seven_seg_scanner #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int REFRESH_HZ = 1000,
    parameter int GUARD      = 16,
    parameter int LZ_BLANK   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] s1,
    input  logic [3:0] s2,
    input  logic [3:0] m1,
    input  logic [3:0] m2,
    input  logic [3:0] h1,
    input  logic [3:0] h2,
    input  logic       mode,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int DIG_CYCLES = CLK_HZ / (4 * REFRESH_HZ);
    localparam int CW         = (DIG_CYCLES > 1) ? $clog2(DIG_CYCLES) : 1;
    localparam int HALF       = CLK_HZ / 2;
    localparam int BW         = (HALF > 1) ? $clog2(HALF) : 1;

    localparam logic [CW-1:0] CNT_LAST   = CW'(DIG_CYCLES - 1);
    localparam logic [CW-1:0] CNT_GUARD  = CW'(GUARD);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(HALF - 1);
    localparam logic [BW-1:0] BLINK_ONE  = BW'(1);
    localparam logic          LZ_EN      = (LZ_BLANK != 0);

    // Active-low gfedcba pattern; anything that is not a decimal digit shows a dash.
    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'h40;
            4'd1:    p = 7'h79;
            4'd2:    p = 7'h24;
            4'd3:    p = 7'h30;
            4'd4:    p = 7'h19;
            4'd5:    p = 7'h12;
            4'd6:    p = 7'h02;
            4'd7:    p = 7'h78;
            4'd8:    p = 7'h00;
            4'd9:    p = 7'h10;
            default: p = 7'h3F;
        endcase
        return p;
    endfunction

    logic [CW-1:0] cnt_r;
    logic [1:0]    idx_r;
    logic          mode_meta_r;
    logic          mode_sync_r;
    logic          mode_lat_r;
    logic [BW-1:0] blink_cnt_r;
    logic          blink_r;
    logic [3:0]    an_r;
    logic [6:0]    seg_r;
    logic          dp_r;

    logic          slot_end_s;
    logic          frame_end_s;
    logic          guard_s;
    logic          blank_s;
    logic [3:0]    digit_s;
    logic [3:0]    an_s;
    logic [6:0]    seg_s;
    logic          dp_s;

    assign slot_end_s  = (cnt_r == CNT_LAST);
    assign frame_end_s = slot_end_s && (idx_r == 2'd3);
    assign guard_s     = (cnt_r < CNT_GUARD);

    // Slot counter and digit index: index advances each time a slot completes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= '0;
            idx_r <= 2'd0;
        end else if (slot_end_s) begin
            cnt_r <= '0;
            idx_r <= idx_r + 2'd1;
        end else begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

    // Mode switch synchroniser; the used mode only changes between frames.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_meta_r <= 1'b0;
            mode_sync_r <= 1'b0;
            mode_lat_r  <= 1'b0;
        end else begin
            mode_meta_r <= mode;
            mode_sync_r <= mode_meta_r;
            mode_lat_r  <= frame_end_s ? mode_sync_r : mode_lat_r;
        end
    end

    // Half-second timebase for the blinking separator dot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_cnt_r <= '0;
            blink_r     <= 1'b0;
        end else if (blink_cnt_r == BLINK_LAST) begin
            blink_cnt_r <= '0;
            blink_r     <= ~blink_r;
        end else begin
            blink_cnt_r <= blink_cnt_r + BLINK_ONE;
        end
    end

    // Select the source digit for the current slot from the latched mode.
    always_comb begin
        digit_s = 4'd0;
        case ({mode_lat_r, idx_r})
            3'b000:  digit_s = m1;
            3'b001:  digit_s = m2;
            3'b010:  digit_s = h1;
            3'b011:  digit_s = h2;
            3'b100:  digit_s = s1;
            3'b101:  digit_s = s2;
            3'b110:  digit_s = m1;
            3'b111:  digit_s = m2;
            default: digit_s = 4'd0;
        endcase
    end

    // Next anode/segment/dot values for the output flops.
    always_comb begin
        blank_s = LZ_EN && !mode_lat_r && (idx_r == 2'd3) && (h2 == 4'd0);
        an_s    = (guard_s || blank_s) ? 4'hF : ~(4'b0001 << idx_r);
        seg_s   = seg_encode(digit_s);
        dp_s    = !((idx_r == 2'd2) && !guard_s && (mode_lat_r || blink_r));
    end

    // Output flops: only registered values ever reach the pins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an_r  <= 4'hF;
            seg_r <= 7'h7F;
            dp_r  <= 1'b1;
        end else begin
            an_r  <= an_s;
            seg_r <= seg_s;
            dp_r  <= dp_s;
        end
    end

    assign an  = an_r;
    assign seg = seg_r;
    assign dp  = dp_r;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: two instances (leading-zero blanking on/off)
// are compared every cycle against a cycle-number model, plus directed
// literal expectations at hand-picked edges.
module tb_seven_seg_scanner;

    localparam int CLK_HZ     = 400;
    localparam int REFRESH_HZ = 10;
    localparam int GUARD      = 2;
    localparam int SLOT       = CLK_HZ / (4 * REFRESH_HZ);
    localparam int FRAME      = 4 * SLOT;
    localparam int HALF       = CLK_HZ / 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] s1, s2, m1, m2, h1, h2;
    logic       mode;
    logic [3:0] an_a, an_b;
    logic [6:0] seg_a, seg_b;
    logic       dp_a, dp_b;

    seven_seg_scanner #(.CLK_HZ(CLK_HZ), .REFRESH_HZ(REFRESH_HZ), .GUARD(GUARD), .LZ_BLANK(1)) dut_a (
        .clk(clk), .rst(rst), .s1(s1), .s2(s2), .m1(m1), .m2(m2), .h1(h1), .h2(h2),
        .mode(mode), .an(an_a), .seg(seg_a), .dp(dp_a));

    seven_seg_scanner #(.CLK_HZ(CLK_HZ), .REFRESH_HZ(REFRESH_HZ), .GUARD(GUARD), .LZ_BLANK(0)) dut_b (
        .clk(clk), .rst(rst), .s1(s1), .s2(s2), .m1(m1), .m2(m2), .h1(h1), .h2(h2),
        .mode(mode), .an(an_b), .seg(seg_b), .dp(dp_b));

    always #5 clk = ~clk;

    int         vectors = 0;
    int         errors  = 0;
    logic [6:0] seg_tab [16];

    // Inputs seen at each edge; p counts cycles since reset release.
    int         ecount = 0;
    int         sn_p   = 0;
    bit         valid  = 1'b0;
    logic [3:0] sn_d [6];
    bit         mode_hist [2048];

    task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Expected outputs after the edge that closes cycle p.
    function automatic void model(input int p, input bit lz,
                                  output logic [3:0] ean, output logic [6:0] eseg, output logic edp);
        int         cnt;
        int         idx;
        int         f;
        bit         m;
        bit         blink;
        bit         blank;
        logic [3:0] d;
        logic [3:0] onehot;
        cnt    = p % SLOT;
        idx    = (p / SLOT) % 4;
        f      = p / FRAME;
        m      = (f == 0) ? 1'b0 : mode_hist[f * FRAME - 3];
        blink  = ((p / HALF) % 2) == 1;
        d      = sn_d[idx + (m ? 0 : 2)];
        blank  = lz && !m && (idx == 3) && (sn_d[5] == 4'd0);
        onehot = 4'b0001 << idx;
        ean    = (cnt < GUARD || blank) ? 4'hF : ~onehot;
        eseg   = seg_tab[d];
        edp    = !((idx == 2) && (cnt >= GUARD) && (m || blink));
    endfunction

    // Snapshot inputs at every active edge.
    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            ecount = 0;
            valid  = 1'b0;
        end else begin
            sn_d = '{s1, s2, m1, m2, h1, h2};
            if (ecount < 2048) mode_hist[ecount] = mode;
            sn_p = ecount;
            ecount++;
            valid = 1'b1;
        end
    end

    // Compare both instances against the model on every falling edge.
    initial forever begin
        logic [3:0] ean;
        logic [6:0] eseg;
        logic       edp;
        @(negedge clk);
        if (!rst || !valid) begin
            check("rst_an_a", {3'b000, an_a}, 7'h0F);
            check("rst_seg_a", seg_a, 7'h7F);
            check("rst_dp_a", {6'b0, dp_a}, 7'h01);
            check("rst_an_b", {3'b000, an_b}, 7'h0F);
        end else begin
            model(sn_p, 1'b1, ean, eseg, edp);
            check("mdl_an_a", {3'b000, an_a}, {3'b000, ean});
            check("mdl_dp_a", {6'b0, dp_a}, {6'b0, edp});
            if (ean != 4'hF) check("mdl_seg_a", seg_a, eseg);
            model(sn_p, 1'b0, ean, eseg, edp);
            check("mdl_an_b", {3'b000, an_b}, {3'b000, ean});
            check("mdl_dp_b", {6'b0, dp_b}, {6'b0, edp});
            if (ean != 4'hF) check("mdl_seg_b", seg_b, eseg);
        end
    end

    // Advance until the given number of edges since release have occurred.
    task automatic at_edge(input int target);
        int k;
        k = 0;
        while (ecount < target && k < 5000) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (ecount != target) begin
            vectors++;
            errors++;
            $display("FAIL edge_wait: got %0d expected %0d", ecount, target);
        end
    endtask

    initial begin
        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
        rst = 1'b0; mode = 1'b0;
        s1 = 4'd7; s2 = 4'd5; m1 = 4'd4; m2 = 4'd3; h1 = 4'd2; h2 = 4'd1;
        repeat (3) @(posedge clk);
        #1;
        check("lit_rst_an", {3'b000, an_a}, 7'h0F);
        check("lit_rst_seg", seg_a, 7'h7F);
        check("lit_rst_dp", {6'b0, dp_a}, 7'h01);
        @(negedge clk); #1; rst = 1'b1;

        at_edge(1);  check("lit_guard0", {3'b000, an_a}, 7'h0F);
        at_edge(2);  check("lit_guard1", {3'b000, an_a}, 7'h0F);
        at_edge(3);  check("lit_i0_an", {3'b000, an_a}, 7'h0E); check("lit_i0_seg", seg_a, 7'h19);
        at_edge(13); check("lit_i1_an", {3'b000, an_a}, 7'h0D); check("lit_i1_seg", seg_a, 7'h30);
        at_edge(23); check("lit_i2_an", {3'b000, an_a}, 7'h0B); check("lit_i2_seg", seg_a, 7'h24);
        at_edge(33); check("lit_i3_an", {3'b000, an_a}, 7'h07); check("lit_i3_seg", seg_a, 7'h79);

        at_edge(40); h2 = 4'd0; h1 = 4'd9;
        at_edge(41); check("lit_frame_guard", {3'b000, an_a}, 7'h0F);
        at_edge(63); check("lit_h1_9_an", {3'b000, an_a}, 7'h0B); check("lit_h1_9_seg", seg_a, 7'h10);
        at_edge(73); check("lit_lz_blank", {3'b000, an_a}, 7'h0F);
                     check("lit_nolz_an", {3'b000, an_b}, 7'h07); check("lit_nolz_seg", seg_b, 7'h40);
        at_edge(79); check("lit_lz_blank_end", {3'b000, an_a}, 7'h0F);

        at_edge(80); h2 = 4'd1; h1 = 4'd2; m1 = 4'hC;
        at_edge(83); check("lit_bad_an", {3'b000, an_a}, 7'h0E); check("lit_bad_seg", seg_a, 7'h3F);
        at_edge(90); m1 = 4'd4;

        at_edge(131); mode = 1'b1;
        at_edge(153); check("lit_old_mode_an", {3'b000, an_a}, 7'h07); check("lit_old_mode_seg", seg_a, 7'h79);
        at_edge(163); check("lit_new_mode_an", {3'b000, an_a}, 7'h0E); check("lit_new_mode_seg", seg_a, 7'h78);
        at_edge(181); check("lit_dp_guard", {6'b0, dp_a}, 7'h01);
        at_edge(183); check("lit_dp_steady", {6'b0, dp_a}, 7'h00);

        at_edge(201); mode = 1'b0;
        at_edge(215); mode = 1'b1;
        at_edge(243); check("lit_pulse_an", {3'b000, an_a}, 7'h0E); check("lit_pulse_seg", seg_a, 7'h78);

        at_edge(250); mode = 1'b0;
        at_edge(283); check("lit_back_hhmm", seg_a, 7'h19);
        at_edge(303); check("lit_blink_on", {6'b0, dp_a}, 7'h00);
        at_edge(423); check("lit_blink_off", {6'b0, dp_a}, 7'h01);
        at_edge(623); check("lit_blink_on2", {6'b0, dp_a}, 7'h00);

        at_edge(705); check("lit_pre_rst_an", {3'b000, an_a}, 7'h0B);
        #2; rst = 1'b0;
        #1;
        check("lit_async_an", {3'b000, an_a}, 7'h0F);
        check("lit_async_seg", seg_a, 7'h7F);
        check("lit_async_dp", {6'b0, dp_a}, 7'h01);
        @(negedge clk); #1; rst = 1'b1;
        at_edge(2);  check("lit_rs_guard", {3'b000, an_a}, 7'h0F);
        at_edge(3);  check("lit_rs_an", {3'b000, an_a}, 7'h0E); check("lit_rs_seg", seg_a, 7'h19);
        at_edge(45);
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
- Downstream display stage for the real-time clock. Consumes the six BCD digits produced by the clock core: s1/s2 (seconds), m1/m2 (minutes), h1/h2 (hours).
- Time-multiplexes four of those digits onto the Basys3 4-digit common-anode seven-segment display.
- Provides HH.MM / MM.SS mode select, leading-zero blanking, a blinking separator decimal point and an anti-ghosting guard interval.

Parameters:
- CLK_HZ, 100_000_000, input clock frequency in Hz.
- REFRESH_HZ, 1000, full 4-digit frame rate in Hz. DIG_CYCLES = CLK_HZ/(4*REFRESH_HZ) clocks per digit slot. Integer division; DIG_CYCLES must be >= GUARD+2.
- GUARD, 16, clocks at the start of each slot during which all anodes are off.
- LZ_BLANK, 1, when 1, blank the leading hour digit when h2==0 in HH.MM mode.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- s1,s2,m1,m2,h1,h2  in  4 each  BCD digits, ones/tens of sec/min/hour.
- mode  in  1  0 = HH.MM, 1 = MM.SS. Asynchronous (slide switch).
- an  out  4  anode enables, active-low; an[0] = rightmost digit.
- seg  out  7  cathodes, active-low, seg[6:0] = g,f,e,d,c,b,a.
- dp  out  1  decimal point cathode, active-low.

Behaviour:
- Reset (rst=0, async): an=4'hF, seg=7'h7F, dp=1. Slot counter=0, digit index=0, mode sync flops=0, latched mode=0, blink counter=0, blink phase=0.
- Slot counter:
  - Counts 0..DIG_CYCLES-1.
  - On wrap, the digit index increments 0->1->2->3->0.
- Mode handling:
  - mode passes through a 2-flop synchroniser.
  - The latched mode updates only at frame end (slot counter == DIG_CYCLES-1 and index == 3).
  - A mid-frame toggle never produces a mixed frame.
- Digit mapping (index : source):
  - mode 0: 0:m1, 1:m2, 2:h1, 3:h2.
  - mode 1: 0:s1, 1:s2, 2:m1, 3:m2.
- Segment encoding (hex, active-low gfedcba):
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78, 8:00, 9:10.
  - Any value 10..15: 3F (dash, g only).
- Anodes:
  - an = ~(1<<index), except all high (4'hF) when slot counter < GUARD.
  - Also all high for index 3 when LZ_BLANK=1, mode 0 and h2==0.
- Decimal point:
  - Active (dp=0) only during index 2 slots outside the guard.
  - mode 0: active only while blink phase == 1.
  - mode 1: active steadily.
- Blink counter:
  - Free-running, 0..CLK_HZ/2-1.
  - Toggles blink phase on wrap, giving 1 Hz at 50% duty.
- Output registers:
  - an, seg and dp are registered: they reflect the counter, index, mode and digit inputs of the previous cycle (1-cycle latency).
  - Digit input changes mid-slot appear on seg one cycle later.
  - No glitch: only registered values drive the pins.
- Reset mid-scan: outputs return immediately to the reset values. Scanning restarts at index 0 with a full guard interval after release.

Test Plan:
(All with CLK_HZ=400, REFRESH_HZ=10, GUARD=2, so DIG_CYCLES=10 and the blink half-period is 200 clocks.)
- Reset: hold rst=0 -> an=F, seg=7F, dp=1. Release; first clock edges -> an=F for the guard, then an=E.
- mode=0, digits h2=1,h1=2,m2=3,m1=4 -> slots 0..3 show seg 19,30,24,79 with an E,D,B,7. Each slot has 2 guard clocks with an=F. Frame length = 40 clocks.
- Leading zero: mode=0, h2=0, h1=9 -> index 3 slot keeps an=F throughout. Index 2 shows seg=10.
  - Same stimulus with LZ_BLANK=0 -> index 3 shows an=7, seg=40.
- Mode switch: toggle mode 0->1 during index 1 -> current frame completes in HH.MM. The next frame shows s1,s2,m1,m2.
  - A mode pulse shorter than the sync window plus frame remainder, returning before frame end, has no effect.
- Invalid BCD: m1=4'hC -> its slot shows seg=3F.
- DP: mode=0 -> dp=0 during index 2 slots only in alternate 200-clock windows.
  - mode=1 -> dp=0 in every index 2 slot outside the guard.
- Async reset asserted mid-slot at index 2 -> outputs go to reset values without waiting for a clock edge. Scan resumes at index 0 after release.
